interrupt_arbiter: RTL and testbench

Sequences interrupt delivery from up to N_SRC peripheral sources to the CPU core of the ATMega32A emulator. Each source owns a set/clear pending flag with set-dominant hardware semantics and clear-dominant software semantics. The arbiter masks the flags, selects the highest-priority request, and runs a request/acknowledge/return handshake with the instruction sequencer. It sits between the peripheral blocks (timers, USART, external-interrupt pins) and the core's control unit.

---
 rtl/interrupt_arbiter.sv | 80 ++++++++
 tb/tb_interrupt_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: masked fixed-priority interrupt arbiter with set/clear pending flags
// and a req/ack/reti handshake toward the core's instruction sequencer.
module interrupt_arbiter #(
    parameter int N_SRC = 8,
    localparam int IDX_W = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_set,
    input  logic [N_SRC-1:0] irq_en,
    input  logic             i_flag,
    input  logic             clr_we,
    input  logic [N_SRC-1:0] clr_data,
    input  logic             irq_ack,
    input  logic             reti,
    output logic             irq_req,
    output logic [IDX_W-1:0] irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] overrun
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t           state_q;
    logic [N_SRC-1:0] pending_q, pending_d, overrun_q, overrun_d, elig, clr, hw_clr;
    logic [IDX_W-1:0] irq_id_q, winner;
    logic             irq_req_q, in_service_q, ack, withdraw;
    assign elig     = pending_q & irq_en & {N_SRC{i_flag}};
    assign clr      = clr_we ? clr_data : '0;
    assign ack      = state_q == REQ && irq_ack;
    assign hw_clr   = ack ? (N_SRC)'(1) << irq_id_q : '0;
    // a software clear of the held source is seen on the inputs so the withdraw is not a cycle late
    assign withdraw = !pending_q[irq_id_q] || !irq_en[irq_id_q] || !i_flag ||
                      (clr_we && clr_data[irq_id_q]);
    // an acknowledge consumes the old event, so a coincident set is a fresh one, not an overrun
    assign pending_d = ~clr & (irq_set | (pending_q & ~hw_clr));
    assign overrun_d = ~clr & (overrun_q | (irq_set & pending_q & ~hw_clr));
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (elig[i]) winner = IDX_W'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overrun_q    <= '0;
            irq_id_q     <= '0;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: if (|elig) begin
                    irq_id_q  <= winner;
                    irq_req_q <= 1'b1;
                    state_q   <= REQ;
                end
                REQ: if (irq_ack) begin
                    irq_req_q    <= 1'b0;
                    in_service_q <= 1'b1;
                    state_q      <= SERVICE;
                end else if (withdraw) begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
                SERVICE: if (reti) begin
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed handshake scenarios plus random traffic, all checked
// against a per-bit behavioural model of the flag and handshake rules.
module tb_interrupt_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] irq_set = '0, irq_en = '0, clr_data = '0;
    logic       i_flag = 1'b0, clr_we = 1'b0, irq_ack = 1'b0, reti = 1'b0;
    logic       irq_req, in_service;
    logic [2:0] irq_id;
    logic [7:0] pending, overrun;
    int n_tests = 0, n_fail = 0;
    // model state: mode 0 idle, 1 requesting, 2 servicing
    logic [7:0] m_pend, m_ovr;
    logic [2:0] m_id;
    logic       m_req, m_svc;
    int         m_mode;

    interrupt_arbiter #(.N_SRC(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_set(irq_set), .irq_en(irq_en), .i_flag(i_flag),
        .clr_we(clr_we), .clr_data(clr_data), .irq_ack(irq_ack), .reti(reti),
        .irq_req(irq_req), .irq_id(irq_id), .in_service(in_service),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_ovr = '0; m_id = '0; m_req = 1'b0; m_svc = 1'b0; m_mode = 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pending"}, {24'd0, pending}, {24'd0, m_pend});
        chk({tag, ".overrun"}, {24'd0, overrun}, {24'd0, m_ovr});
        chk({tag, ".irq_req"}, {31'd0, irq_req}, {31'd0, m_req});
        chk({tag, ".in_service"}, {31'd0, in_service}, {31'd0, m_svc});
        chk({tag, ".irq_id"}, {29'd0, irq_id}, {29'd0, m_id});
    endtask

    // drive one cycle of inputs, advance the model by the rules, clock, then compare
    task automatic cyc(input logic [7:0] s, e, input logic f, cw, input logic [7:0] cd,
                       input logic a, r, input string tag);
        logic [7:0] np, no;
        logic       acked, hit;
        int         w;
        irq_set = s; irq_en = e; i_flag = f; clr_we = cw; clr_data = cd; irq_ack = a; reti = r;
        acked = (m_mode == 1) && a;
        for (int i = 0; i < 8; i++) begin
            hit = acked && (int'(m_id) == i);
            if (cw && cd[i]) begin
                np[i] = 1'b0; no[i] = 1'b0;
            end else if (s[i]) begin
                np[i] = 1'b1; no[i] = m_ovr[i] | (m_pend[i] & ~hit);
            end else begin
                np[i] = hit ? 1'b0 : m_pend[i]; no[i] = m_ovr[i];
            end
        end
        @(posedge clk);
        #1;
        if (m_mode == 0) begin
            w = -1;
            for (int i = 0; i < 8; i++)
                if (w < 0 && f && e[i] && m_pend[i]) w = i;
            if (w >= 0) begin m_id = 3'(w); m_req = 1'b1; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (a) begin
                m_req = 1'b0; m_svc = 1'b1; m_mode = 2;
            end else if (!m_pend[m_id] || !e[m_id] || !f || (cw && cd[m_id])) begin
                m_req = 1'b0; m_mode = 0;
            end
        end else if (r) begin
            m_svc = 1'b0; m_mode = 0;
        end
        m_pend = np; m_ovr = no;
        cmp_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        rst_n = 1'b1;
        // single source: set at 0, pending at 1, request at 2, ack at 4, reti at 7
        cyc(8'h20, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "single");
        chk("single.pend1", {24'd0, pending}, 32'h20);
        idle(1, "single");
        chk("single.req2", {31'd0, irq_req}, 32'd1);
        chk("single.id2", {29'd0, irq_id}, 32'd5);
        idle(2, "single");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "single");
        chk("single.pend5", {24'd0, pending}, 32'h00);
        chk("single.svc5", {31'd0, in_service}, 32'd1);
        idle(2, "single");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "single");
        chk("single.svc8", {31'd0, in_service}, 32'd0);
        // priority: 2 before 7, then a source-0 set does not preempt the held id 7
        cyc(8'h84, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "prio");
        idle(1, "prio");
        chk("prio.first", {29'd0, irq_id}, 32'd2);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "prio");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "prio");
        chk("prio.gap", {31'd0, irq_req}, 32'd0);
        idle(1, "prio");
        chk("prio.second_req", {31'd0, irq_req}, 32'd1);
        chk("prio.second_id", {29'd0, irq_id}, 32'd7);
        cyc(8'h01, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "prio");
        idle(1, "prio");
        chk("prio.nopreempt", {29'd0, irq_id}, 32'd7);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "prio");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "prio");
        idle(1, "prio");
        chk("prio.src0", {29'd0, irq_id}, 32'd0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "prio");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "prio");
        // withdraw by dropping i_flag; a late ack is ignored
        cyc(8'h08, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "wd");
        idle(1, "wd");
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "wd");
        chk("wd.req", {31'd0, irq_req}, 32'd0);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "wd");
        chk("wd.lateack", {31'd0, in_service}, 32'd0);
        chk("wd.stillpend", {31'd0, pending[3]}, 32'd1);
        // withdraw by software clear of the held source
        idle(1, "wd2");
        cyc(8'h00, 8'hFF, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0, "wd2");
        chk("wd2.req", {31'd0, irq_req}, 32'd0);
        idle(2, "wd2");
        // collisions: clear beats set; set during ack re-requests after reti
        cyc(8'h02, 8'hFF, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, "col");
        chk("col.clrwins", {31'd0, pending[1]}, 32'd0);
        cyc(8'h02, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "col");
        idle(1, "col");
        cyc(8'h02, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "col");
        chk("col.keep", {31'd0, pending[1]}, 32'd1);
        chk("col.noovr", {31'd0, overrun[1]}, 32'd0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "col");
        idle(1, "col");
        chk("col.rereq", {29'd0, irq_id}, 32'd1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "col");
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "col");
        // overrun on bit 4, then software clear of both flags
        cyc(8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ovr");
        cyc(8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ovr");
        chk("ovr.set", {31'd0, overrun[4]}, 32'd1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, "ovr");
        chk("ovr.clr", {30'd0, pending[4], overrun[4]}, 32'd0);
        // asynchronous reset mid-request
        cyc(8'h40, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "ar");
        idle(1, "ar");
        chk("ar.inreq", {31'd0, irq_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all("ar.async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3, "ar.after");
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(8'($urandom & $urandom & $urandom),
                ($urandom % 8 == 0) ? 8'($urandom) : 8'hFF,
                ($urandom % 10) != 0,
                ($urandom % 6) == 0,
                8'($urandom & $urandom),
                m_req ? 1'($urandom % 2) : ($urandom % 8 == 0),
                m_svc ? ($urandom % 3 == 0) : ($urandom % 8 == 0),
                "rand");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
